serial_bit_source: RTL
======================

# serial_bit_source

- Parallel-to-serial stage that feeds the team's serial sequence detectors.
- Accepts `WIDTH`-bit words over a valid/ready handshake and buffers one word in a holding register.
- Shifts words out one bit per `clk`, with no gap between consecutive words, on a registered serial line that the detector samples every clock.

## Interface
- `WIDTH`, 8, word width in bits (≥2)
- `MSB_FIRST`, 1, 1 = bit `WIDTH-1` sent first, 0 = bit 0 sent first
- `IDLE_BIT`, 1'b0, level driven on `ser_out` when no word is being shifted

- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_data`  in  WIDTH  word to serialize
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  block can accept a word this cycle
- `ser_out`  out  1  serial bit, registered
- `ser_valid`  out  1  `ser_out` carries a data bit this cycle, registered
- `frame_last`  out  1  high with the final bit of each word, registered
- `busy`  out  1  shift register or holding register occupied

## Operation
- Storage:
  - holding register `hold` plus flag `hold_full`
  - shift register `sh`
  - bit counter `cnt`, width `$clog2(WIDTH)`
  - state `IDLE` / `SHIFT`
- Accept: a word is accepted when `in_valid && in_ready`; it is written to `hold` and `hold_full` is set.
- `load_now = hold_full && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`
- `in_ready = !hold_full || load_now`. This is combinational from registered state only; it never depends on `in_valid`.
- On `load_now`:
  - `sh <= hold`, `cnt <= 0`, `state <= SHIFT`
  - `hold_full` clears unless a new word is accepted on the same edge; in that case `hold` takes the new word and stays full.
- `SHIFT`, each cycle:
  - present the current bit: `sh[WIDTH-1]` if `MSB_FIRST`, else `sh[0]`
  - shift `sh` one position toward the presented end
  - `cnt <= cnt+1`
- At `cnt==WIDTH-1`:
  - without `load_now`: next state is `IDLE`
  - with `load_now`: the next word starts immediately, with no idle cycle
- Registered outputs, updated each edge from the next-state logic:
  - `ser_out` = bit being sent, or `IDLE_BIT` when idle
  - `ser_valid` = 1 while in `SHIFT`
  - `frame_last` = 1 on the bit with `cnt==WIDTH-1`
- `busy = hold_full || state==SHIFT || ser_valid`
- `in_valid` dropping while `in_ready` is low is a protocol violation. Behaviour is unspecified and the bench flags it.

## Timing
- Reset values:
  - `state=IDLE`, `hold_full=0`, `cnt=0`, `sh=0`
  - `ser_out=IDLE_BIT`, `ser_valid=0`, `frame_last=0`
  - `in_ready=1`, `busy=0`
- Latency: word accepted at edge k → loaded at edge k+1 → first bit on `ser_out`/`ser_valid` after edge k+2.
- Each word occupies exactly `WIDTH` consecutive `ser_valid` cycles.
- Sustained throughput: one word per `WIDTH` cycles when `in_valid` is held high.
- Back-to-back words: `frame_last` of word n is immediately followed by bit 0 of word n+1. `ser_valid` never drops.
- Backpressure: while shifting with `hold_full`, `in_ready` stays 0 until the `cnt==WIDTH-1` cycle, then returns to 1.
- Reset mid-operation discards both the shifting word and the held word. Outputs return to reset values asynchronously; no partial frame resumes after reset.
- `cnt` never exceeds `WIDTH-1`. Wrap occurs only through a reload to 0.

## Structure
- Shared package `ser_pkg`:
  - state enum `ser_state_t {S_IDLE, S_SHIFT}`
  - default-width constant `SER_WIDTH_DEF=8`
- One sub-module: `word_hold_reg`, a one-entry buffer with `wr_en`, `rd_en`, `full` and data; simultaneous read and write are supported.
- Everything else stays in the top module: FSM, counter, shift register, output registers.

## Test plan
- Single word, `WIDTH=8`, `MSB_FIRST=1`, `in_data=8'h15` → `ser_out` = 0,0,0,1,0,1,0,1 over 8 `ser_valid` cycles starting 2 cycles after accept; `frame_last` on the 8th bit; then `ser_out=IDLE_BIT`, `busy=0`.
- Back-to-back words 8'hA5, 8'h3C with `in_valid` held high → 16 contiguous `ser_valid` cycles: 1010_0101_0011_1100; `frame_last` at bits 8 and 16.
- Backpressure: three words offered continuously → `in_ready` low from the second accept until the `cnt==7` cycle of word 1; all 24 bits delivered in order with no gaps.
- `MSB_FIRST=0`, `in_data=8'h15` → `ser_out` = 1,0,1,0,1,0,0,0.
- Reset asserted at bit 4 of 8'hFF with a word held → same cycle: `ser_out=0`, `ser_valid=0`, `in_ready=1`, `busy=0`; no further bits after release.
- Idle: no `in_valid` for 20 cycles after reset → `ser_valid=0`, `ser_out=IDLE_BIT` throughout.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and defaults for the serial bit source.
package ser_pkg;
  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;
  localparam int SER_WIDTH_DEF = 8;
endpackage

// File: rtl/word_hold_reg.sv
// One-entry word buffer; a write on the same edge as a read keeps it full.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      full    <= 1'b0;
    end else begin
      if (wr_en) rd_data <= wr_data;
      if (wr_en)      full <= 1'b1;
      else if (rd_en) full <= 1'b0;
    end
  end
endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial stage: buffers one word and shifts words out gaplessly
// on a registered serial line.
module serial_bit_source
  import ser_pkg::*;
#(
  parameter int   WIDTH     = SER_WIDTH_DEF,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ser_state_t       state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, accept, load_now, last_bit;
  logic             ser_out_d, ser_valid_d, frame_last_d;

  assign last_bit = (state == S_SHIFT) && (cnt == CW'(WIDTH-1));
  assign load_now = hold_full && ((state == S_IDLE) || last_bit);
  assign in_ready = !hold_full || load_now;
  assign accept   = in_valid && in_ready;
  assign busy     = hold_full || (state == S_SHIFT) || ser_valid;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_en   (load_now),
    .rd_data (hold_data),
    .full    (hold_full)
  );

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    sh_d         = sh;
    ser_out_d    = IDLE_BIT;
    ser_valid_d  = 1'b0;
    frame_last_d = 1'b0;
    if (state == S_SHIFT) begin
      ser_out_d    = MSB_FIRST ? sh[WIDTH-1] : sh[0];
      ser_valid_d  = 1'b1;
      frame_last_d = last_bit;
      sh_d         = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
      // Clear rather than increment on the last bit so cnt never passes WIDTH-1.
      cnt_d        = last_bit ? '0 : cnt + CW'(1);
      if (last_bit) state_d = S_IDLE;
    end
    if (load_now) begin
      sh_d    = hold_data;
      cnt_d   = '0;
      state_d = S_SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sh         <= '0;
      ser_out    <= IDLE_BIT;
      ser_valid  <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sh         <= sh_d;
      ser_out    <= ser_out_d;
      ser_valid  <= ser_valid_d;
      frame_last <= frame_last_d;
    end
  end
endmodule
